// File: rtl/parking_pkg.sv
// Shared encodings, FSM state type and the slot-to-route ROM for the parking
// sequencers (entry-side route sequencer and the exit-gate sequencer).
package parking_pkg;

  localparam int HOP_W      = 2;
  localparam int ROM_HOPS   = 4;
  localparam int ROM_PATH_W = HOP_W * ROM_HOPS;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_W = 2'b01;
  localparam logic [1:0] DIR_E = 2'b10;
  localparam logic [1:0] DIR_S = 2'b11;

  localparam logic [1:0] TURN_NONE = 2'b00;
  localparam logic [1:0] TURN_C1   = 2'b01;
  localparam logic [1:0] TURN_C2   = 2'b10;
  localparam logic [1:0] TURN_C3   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUTE,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  // Routes are packed first hop in the MSBs; a 00 code ends the route early.
  function automatic logic [ROM_PATH_W-1:0] route_for_slot(input int unsigned slot);
    logic [ROM_PATH_W-1:0] path;
    case (slot)
      0:       path = 8'b00_00_00_00;
      1:       path = 8'b11_00_00_00;
      2:       path = 8'b10_01_11_00;
      3:       path = 8'b01_10_00_00;
      4:       path = 8'b11_11_00_00;
      5:       path = 8'b01_01_10_11;
      6:       path = 8'b10_00_00_00;
      7:       path = 8'b11_10_01_00;
      default: path = '0;
    endcase
    return path;
  endfunction

endpackage

// File: rtl/hop_timer.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count sits at TIMEOUT-1. Never wraps.
module hop_timer #(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/route_sequencer.sv
// Turns a slot request into a packed route and feeds the 4-way junction one
// hop at a time, tracking heading, arrival and stalled cars.
module route_sequencer
  import parking_pkg::*;
#(
  parameter int SLOT_W  = 3,
  parameter int HOPS    = 4,
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [SLOT_W-1:0]   req_slot,
  output logic                req_ready,
  input  logic [1:0]          entry_dir,
  output logic [2*HOPS-1:0]   path_data,
  output logic [1:0]          input_dir,
  input  logic [1:0]          junc_out_dir,
  input  logic                hop_pass,
  input  logic                clear_err,
  output logic                busy,
  output logic                arrived,
  output logic                timeout_err,
  output logic [2:0]          hop_cnt
);

  localparam int PATH_W = HOP_W * HOPS;

  seq_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        heading_q, heading_d;
  logic [PATH_W-1:0] path_q, path_d;
  logic [2:0]        hop_cnt_q, hop_cnt_d;

  logic [PATH_W-1:0] romPath;
  logic [PATH_W-1:0] pathShifted;
  logic [2:0]        hopNext;
  logic              tmrClear;
  logic              tmrEnable;
  logic              tmrExpire;

  // The ROM is laid out for the default hop count; other HOPS values resize it.
  assign romPath     = PATH_W'(route_for_slot(32'(slot_q)));
  assign pathShifted = path_q << HOP_W;
  assign hopNext     = (hop_cnt_q == 3'(HOPS)) ? hop_cnt_q : hop_cnt_q + 3'd1;

  hop_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_hop_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmrClear),
    .enable (tmrEnable),
    .expire (tmrExpire)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    heading_d   = heading_q;
    path_d      = path_q;
    hop_cnt_d   = hop_cnt_q;
    tmrClear    = 1'b0;
    tmrEnable   = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b0;
    arrived     = 1'b0;
    timeout_err = 1'b0;
    path_data   = '0;
    input_dir   = DIR_N;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        tmrClear  = 1'b1;
        if (req_valid) begin
          slot_d    = req_slot;
          heading_d = entry_dir;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy      = 1'b1;
        path_d    = romPath;
        hop_cnt_d = '0;
        tmrClear  = 1'b1;
        state_d   = (romPath[PATH_W-1 -: HOP_W] == TURN_NONE) ? ST_DONE : ST_ROUTE;
      end

      ST_ROUTE: begin
        busy      = 1'b1;
        path_data = path_q;
        input_dir = heading_q;
        tmrEnable = 1'b1;
        // A pass on the expiry cycle still counts: the car made it.
        if (hop_pass) begin
          heading_d = junc_out_dir;
          path_d    = pathShifted;
          hop_cnt_d = hopNext;
          tmrClear  = 1'b1;
          if ((pathShifted[PATH_W-1 -: HOP_W] == TURN_NONE) || (hopNext == 3'(HOPS))) begin
            state_d = ST_DONE;
          end
        end else if (tmrExpire) begin
          state_d = ST_ERR;
        end
      end

      ST_DONE: begin
        arrived = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        busy        = 1'b1;
        timeout_err = 1'b1;
        if (clear_err) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      heading_q <= DIR_N;
      path_q    <= '0;
      hop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      heading_q <= heading_d;
      path_q    <= path_d;
      hop_cnt_q <= hop_cnt_d;
    end
  end

  assign hop_cnt = hop_cnt_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Self-checking bench for route_sequencer: a route-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_route_sequencer;

  localparam int SLOT_W  = 3;
  localparam int HOPS    = 4;
  localparam int TIMEOUT = 16;
  localparam int TMR_W   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_slot = '0;
  logic       req_ready;
  logic [1:0] entry_dir = '0;
  logic [7:0] path_data;
  logic [1:0] input_dir;
  logic [1:0] junc_out_dir = '0;
  logic       hop_pass = 1'b0;
  logic       clear_err = 1'b0;
  logic       busy;
  logic       arrived;
  logic       timeout_err;
  logic [2:0] hop_cnt;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  route_sequencer #(
    .SLOT_W  (SLOT_W),
    .HOPS    (HOPS),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_slot     (req_slot),
    .req_ready    (req_ready),
    .entry_dir    (entry_dir),
    .path_data    (path_data),
    .input_dir    (input_dir),
    .junc_out_dir (junc_out_dir),
    .hop_pass     (hop_pass),
    .clear_err    (clear_err),
    .busy         (busy),
    .arrived      (arrived),
    .timeout_err  (timeout_err),
    .hop_cnt      (hop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a route is the ROM word; the visible path is that word
  // shifted by the hops done, and the route ends after its leading non-zero codes.
  typedef enum {M_IDLE, M_LOAD, M_ROUTE, M_DONE, M_ERR} mstage_e;

  mstage_e    mStage = M_IDLE;
  int         mSlot = 0;
  logic [7:0] mRom = '0;
  int         mHops = 0;
  logic [1:0] mHeading = '0;
  int         mWait = 0;

  function automatic logic [7:0] romOf(input int s);
    logic [7:0] table_v [8];
    table_v = '{8'h00, 8'hC0, 8'b10011100, 8'b01100000,
                8'hF0, 8'b01011011, 8'h80, 8'b11100100};
    return table_v[s];
  endfunction

  function automatic int leadCount(input logic [7:0] rom);
    int n = 0;
    for (int i = 0; i < HOPS; i++) begin
      if (((rom >> (6 - 2 * i)) & 8'h03) == 8'h00) return n;
      n++;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStage = M_IDLE; mHops = 0; mHeading = '0; mWait = 0; mRom = '0;
    end else begin
      case (mStage)
        M_IDLE: if (req_valid) begin
          mSlot = int'(req_slot); mHeading = entry_dir; mStage = M_LOAD;
        end
        M_LOAD: begin
          mRom = romOf(mSlot); mHops = 0; mWait = 0;
          mStage = (leadCount(mRom) == 0) ? M_DONE : M_ROUTE;
        end
        M_ROUTE: begin
          if (hop_pass) begin
            mHeading = junc_out_dir;
            mHops = (mHops < HOPS) ? mHops + 1 : HOPS;
            mWait = 0;
            if (mHops == leadCount(mRom)) mStage = M_DONE;
          end else if (mWait == TIMEOUT - 1) begin
            mStage = M_ERR;
          end else begin
            mWait++;
          end
        end
        M_DONE: mStage = M_IDLE;
        M_ERR:  if (clear_err) mStage = M_IDLE;
        default: mStage = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && checkEn) begin
      logic [7:0] expPath;
      expPath = (mStage == M_ROUTE) ? (mRom << (2 * mHops)) : 8'h00;
      checkOutput("model.req_ready", 32'(req_ready), 32'(mStage == M_IDLE));
      checkOutput("model.busy", 32'(busy),
                  32'(mStage == M_LOAD || mStage == M_ROUTE || mStage == M_ERR));
      checkOutput("model.arrived", 32'(arrived), 32'(mStage == M_DONE));
      checkOutput("model.timeout_err", 32'(timeout_err), 32'(mStage == M_ERR));
      checkOutput("model.path_data", 32'(path_data), 32'(expPath));
      checkOutput("model.input_dir", 32'(input_dir), 32'((mStage == M_ROUTE) ? mHeading : 2'b00));
      checkOutput("model.hop_cnt", 32'(hop_cnt), 32'(mHops));
    end
  end

  // Drives one cycle of inputs, then returns 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [1:0] e,
                               input logic h, input logic [1:0] j, input logic c);
    req_valid = v; req_slot = s; entry_dir = e;
    hop_pass = h; junc_out_dir = j; clear_err = c;
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'd0, 2'd0, 0, 2'd0, 0);
  endtask

  task automatic startRoute(input logic [2:0] s, input logic [1:0] e);
    applyStimulus(1, s, e, 0, 2'd0, 0);
    applyStimulus(0, 3'd0, 2'd0, 0, 2'd0, 0);
  endtask

  initial begin
    #2;
    checkOutput("reset.path_data", 32'(path_data), 32'h00);
    checkOutput("reset.req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset.busy", 32'(busy), 32'h0);
    checkOutput("reset.hop_cnt", 32'(hop_cnt), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    checkEn = 1'b1;
    idleCycles(2);

    // Slot 2 normal route
    startRoute(3'd2, 2'b00);
    checkOutput("slot2.path0", 32'(path_data), 32'b10011100);
    checkOutput("slot2.dir0", 32'(input_dir), 32'b00);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    checkOutput("slot2.path1", 32'(path_data), 32'b01110000);
    checkOutput("slot2.dir1", 32'(input_dir), 32'b10);
    checkOutput("slot2.hop1", 32'(hop_cnt), 32'd1);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b01, 0);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b11, 0);
    checkOutput("slot2.arrived", 32'(arrived), 32'h1);
    checkOutput("slot2.hop3", 32'(hop_cnt), 32'd3);
    idleCycles(1);
    checkOutput("slot2.arrived_drop", 32'(arrived), 32'h0);
    checkOutput("slot2.idle_ready", 32'(req_ready), 32'h1);

    // Slot 5 uses all four hops
    startRoute(3'd5, 2'b01);
    checkOutput("slot5.path0", 32'(path_data), 32'b01011011);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b00, 0);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b01, 0);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    checkOutput("slot5.path3", 32'(path_data), 32'b11000000);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b11, 0);
    checkOutput("slot5.arrived", 32'(arrived), 32'h1);
    checkOutput("slot5.hop4", 32'(hop_cnt), 32'd4);
    checkOutput("slot5.path_done", 32'(path_data), 32'h00);
    idleCycles(2);

    // Timeout with no hop_pass, hop_pass ignored while in ERR
    startRoute(3'd2, 2'b00);
    idleCycles(TIMEOUT - 1);
    checkOutput("tmo.before", 32'(timeout_err), 32'h0);
    idleCycles(1);
    checkOutput("tmo.err", 32'(timeout_err), 32'h1);
    checkOutput("tmo.path", 32'(path_data), 32'h00);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    idleCycles(2);
    checkOutput("tmo.hold", 32'(timeout_err), 32'h1);
    applyStimulus(0, 3'd0, 2'd0, 0, 2'd0, 1);
    checkOutput("tmo.cleared", 32'(timeout_err), 32'h0);
    checkOutput("tmo.ready", 32'(req_ready), 32'h1);
    idleCycles(1);

    // hop_pass on the expiry cycle wins, and the timer restarts
    startRoute(3'd2, 2'b11);
    idleCycles(TIMEOUT - 1);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b01, 0);
    checkOutput("race.no_err", 32'(timeout_err), 32'h0);
    checkOutput("race.hop1", 32'(hop_cnt), 32'd1);
    checkOutput("race.path1", 32'(path_data), 32'b01110000);
    idleCycles(TIMEOUT - 1);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    checkOutput("race.restart", 32'(timeout_err), 32'h0);
    checkOutput("race.hop2", 32'(hop_cnt), 32'd2);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b00, 0);
    checkOutput("race.arrived", 32'(arrived), 32'h1);
    idleCycles(1);

    // Request during ROUTE is refused and never loaded
    startRoute(3'd2, 2'b00);
    checkOutput("busyreq.ready", 32'(req_ready), 32'h0);
    applyStimulus(1, 3'd7, 2'b11, 0, 2'd0, 0);
    checkOutput("busyreq.path", 32'(path_data), 32'b10011100);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    checkOutput("busyreq.arrived", 32'(arrived), 32'h1);
    idleCycles(3);
    checkOutput("busyreq.idle", 32'(busy), 32'h0);

    // Slot 0: empty route goes straight to DONE
    applyStimulus(1, 3'd0, 2'b10, 0, 2'd0, 0);
    checkOutput("slot0.load_path", 32'(path_data), 32'h00);
    applyStimulus(0, 3'd0, 2'd0, 0, 2'd0, 0);
    checkOutput("slot0.arrived", 32'(arrived), 32'h1);
    checkOutput("slot0.path", 32'(path_data), 32'h00);
    checkOutput("slot0.hop", 32'(hop_cnt), 32'd0);
    idleCycles(2);

    // Reset mid-route aborts without an arrival
    startRoute(3'd2, 2'b00);
    applyStimulus(0, 3'd0, 2'd0, 1, 2'b10, 0);
    checkOutput("rstmid.hop1", 32'(hop_cnt), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("rstmid.path", 32'(path_data), 32'h00);
    checkOutput("rstmid.dir", 32'(input_dir), 32'h0);
    checkOutput("rstmid.busy", 32'(busy), 32'h0);
    checkOutput("rstmid.ready", 32'(req_ready), 32'h1);
    checkOutput("rstmid.arrived", 32'(arrived), 32'h0);
    checkOutput("rstmid.hop", 32'(hop_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
